// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC register and fetch sequencer (BOOT/RUN/HALT); redirect > accept > stall > idle.
// Optional perf counters enabled by defining PC_PERF_COUNT_EN.
module pc_fetch_ctrl #(
  parameter int unsigned    WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc_plus4_in,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] pc_out,
  output logic             imem_req_valid,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
`ifdef PC_PERF_COUNT_EN
  output logic [31:0]      fetch_count,
  output logic [31:0]      redirect_count,
`endif
  output logic             halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q;

  logic halt_go;
  logic accept;

  // halt_req with resume in the same RUN cycle keeps running, so it does not block the accept
  assign halt_go        = (state_q == RUN) && halt_req && !resume;
  assign imem_req_valid = rst_n && (state_q == RUN) && !stall;
  assign accept         = imem_req_valid && imem_req_ready && !halt_go;
  assign halted         = rst_n && (state_q == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_out   <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt_go) state_q <= HALT;
        HALT:    if (resume) state_q <= RUN;
        default: state_q <= BOOT;
      endcase

      if (redirect_valid) begin
        pc_out   <= redirect_target;
        if_valid <= 1'b0;
      end else if (accept) begin
        pc_out   <= pc_plus4_in;
        if_pc    <= pc_out;
        if_valid <= 1'b1;
      end else if (!stall) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef PC_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (accept)         fetch_count    <= fetch_count + 32'd1;
      if (redirect_valid) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule
